// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 two-player key controller.
//   - scancode constants (prefixes, overrun/error codes, mapped keys)
//   - decoder FSM state enumeration
//   - key bit indices within a player's 5-bit key vector
package ps2_pkg;

  localparam int unsigned NUM_KEYS = 5;

  // Prefix and keyboard error codes
  localparam logic [7:0] SC_EXT  = 8'hE0;
  localparam logic [7:0] SC_BRK  = 8'hF0;
  localparam logic [7:0] SC_OVR0 = 8'h00;
  localparam logic [7:0] SC_OVRF = 8'hFF;

  // Player 1, non-extended
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;

  // Player 2, extended arrows plus non-extended Enter
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_ENTER = 8'h5A;

  // Bit positions inside p1keys / p2keys
  localparam logic [2:0] KEY_UP    = 3'd0;
  localparam logic [2:0] KEY_DOWN  = 3'd1;
  localparam logic [2:0] KEY_LEFT  = 3'd2;
  localparam logic [2:0] KEY_RIGHT = 3'd3;
  localparam logic [2:0] KEY_FIRE  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,  // no prefix pending
    ST_BRK     = 2'd1,  // F0 seen
    ST_EXT     = 2'd2,  // E0 seen
    ST_EXT_BRK = 2'd3   // E0 F0 seen
  } ps2_state_t;

  function automatic logic is_prefix(input logic [7:0] c);
    return (c == SC_EXT) || (c == SC_BRK);
  endfunction

endpackage

// File: rtl/ps2_keymap.sv
// ps2_keymap: combinational scancode-to-key lookup.
// Ports:
//   code    in  8  scancode byte (prefixes already stripped)
//   ext     in  1  byte followed an E0 prefix
//   hit     out 1  code maps to a game key
//   player  out 1  0 = player 1, 1 = player 2
//   bit_idx out 3  key bit index (KEY_UP..KEY_FIRE)
module ps2_keymap
  import ps2_pkg::*;
(
  input  logic [7:0] code,
  input  logic       ext,
  output logic       hit,
  output logic       player,
  output logic [2:0] bit_idx
);

  always_comb begin
    hit     = 1'b0;
    player  = 1'b0;
    bit_idx = KEY_UP;
    if (ext) begin
      case (code)
        SC_UP:    begin hit = 1'b1; player = 1'b1; bit_idx = KEY_UP;    end
        SC_DOWN:  begin hit = 1'b1; player = 1'b1; bit_idx = KEY_DOWN;  end
        SC_LEFT:  begin hit = 1'b1; player = 1'b1; bit_idx = KEY_LEFT;  end
        SC_RIGHT: begin hit = 1'b1; player = 1'b1; bit_idx = KEY_RIGHT; end
        default:  ;
      endcase
    end else begin
      case (code)
        SC_W:     begin hit = 1'b1; player = 1'b0; bit_idx = KEY_UP;    end
        SC_S:     begin hit = 1'b1; player = 1'b0; bit_idx = KEY_DOWN;  end
        SC_A:     begin hit = 1'b1; player = 1'b0; bit_idx = KEY_LEFT;  end
        SC_D:     begin hit = 1'b1; player = 1'b0; bit_idx = KEY_RIGHT; end
        SC_SPACE: begin hit = 1'b1; player = 1'b0; bit_idx = KEY_FIRE;  end
        SC_ENTER: begin hit = 1'b1; player = 1'b1; bit_idx = KEY_FIRE;  end
        default:  ;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: turns a PS/2 scancode byte stream into held-key vectors
// for two players.
// Ports:
//   clk        in  1  system clock (rising edge)
//   rst        in  1  synchronous active-high reset
//   code       in  8  scancode byte, valid with code_valid
//   code_valid in  1  one-cycle strobe per received byte
//   frame_err  in  1  one-cycle strobe, receiver framing/parity error
//   p1keys     out 5  player-1 held keys {fire,right,left,down,up}
//   p2keys     out 5  player-2 held keys, same order
//   debugLEDs  out 8  last accepted code byte
//   key_event  out 1  one-cycle pulse when any key bit changed
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] code,
  input  logic       code_valid,
  input  logic       frame_err,
  output logic [4:0] p1keys,
  output logic [4:0] p2keys,
  output logic [7:0] debugLEDs,
  output logic       key_event
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  ps2_state_t    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [4:0]    p1_reg, p1_next;
  logic [4:0]    p2_reg, p2_next;
  logic [7:0]    led_reg, led_next;
  logic          event_reg, event_next;

  logic          map_ext;
  logic          map_hit;
  logic          map_player;
  logic [2:0]    map_bit;
  logic [4:0]    key_mask;
  logic          key_make;
  logic          key_break;

  // The lookup table depends only on which prefix is pending.
  assign map_ext = (state_reg == ST_EXT) || (state_reg == ST_EXT_BRK);

  ps2_keymap u_keymap (
    .code    (code),
    .ext     (map_ext),
    .hit     (map_hit),
    .player  (map_player),
    .bit_idx (map_bit)
  );

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_mask
    assign key_mask[gi] = (map_bit == 3'(gi));
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    p1_next    = p1_reg;
    p2_next    = p2_reg;
    led_next   = led_reg;
    key_make   = 1'b0;
    key_break  = 1'b0;

    if (frame_err) begin
      // A corrupted byte may have been a break we missed: drop everything.
      state_next = ST_IDLE;
      cnt_next   = '0;
      p1_next    = '0;
      p2_next    = '0;
    end else if (code_valid) begin
      led_next = code;
      cnt_next = '0;
      if (code == SC_OVR0 || code == SC_OVRF) begin
        state_next = ST_IDLE;
        p1_next    = '0;
        p2_next    = '0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (code == SC_EXT)      state_next = ST_EXT;
            else if (code == SC_BRK) state_next = ST_BRK;
            else                     key_make = 1'b1;
          end
          ST_EXT: begin
            if (code == SC_BRK)      state_next = ST_EXT_BRK;
            else if (code == SC_EXT) state_next = ST_EXT;
            else begin
              key_make   = 1'b1;
              state_next = ST_IDLE;
            end
          end
          default: begin
            // ST_BRK / ST_EXT_BRK: a second prefix aborts the sequence.
            state_next = ST_IDLE;
            key_break  = !is_prefix(code);
          end
        endcase
      end
    end else if (state_reg != ST_IDLE) begin
      // Abandon a stale prefix; counter holds at its last value.
      if (cnt_reg == CNT_LAST) state_next = ST_IDLE;
      else                     cnt_next   = cnt_reg + CW'(1);
    end

    if (map_hit && key_make) begin
      if (map_player) p2_next = p2_reg | key_mask;
      else            p1_next = p1_reg | key_mask;
    end
    if (map_hit && key_break) begin
      if (map_player) p2_next = p2_reg & ~key_mask;
      else            p1_next = p1_reg & ~key_mask;
    end

    // Typematic repeats and breaks of released keys leave the vectors equal.
    event_next = (p1_next != p1_reg) || (p2_next != p2_reg);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      p1_reg    <= '0;
      p2_reg    <= '0;
      led_reg   <= '0;
      event_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      p1_reg    <= p1_next;
      p2_reg    <= p2_next;
      led_reg   <= led_next;
      event_reg <= event_next;
    end
  end

  assign p1keys    = p1_reg;
  assign p2keys    = p2_reg;
  assign debugLEDs = led_reg;
  assign key_event = event_reg;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl with a short timeout.
module tb_ps2_key_ctrl;

  localparam int unsigned TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] code = 8'h00;
  logic       code_valid = 1'b0;
  logic       frame_err = 1'b0;
  logic [4:0] p1keys, p2keys;
  logic [7:0] debugLEDs;
  logic       key_event;

  int errors = 0;
  int checks = 0;
  int ev_cnt = 0;

  ps2_key_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .code       (code),
    .code_valid (code_valid),
    .frame_err  (frame_err),
    .p1keys     (p1keys),
    .p2keys     (p2keys),
    .debugLEDs  (debugLEDs),
    .key_event  (key_event)
  );

  always #5 clk = ~clk;

  // Count key_event pulses, sampled away from the rising edge.
  always @(negedge clk) if (key_event) ev_cnt++;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the byte's edge.
  task automatic send(input logic [7:0] b);
    code = b;
    code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
    $display("byte %02h -> p1=%05b p2=%05b led=%02h ev=%0b", b, p1keys, p2keys, debugLEDs, key_event);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    check("rst_p1", 16'(p1keys), 16'h0);
    check("rst_p2", 16'(p2keys), 16'h0);
    check("rst_led", 16'(debugLEDs), 16'h0);
    check("rst_ev", 16'(key_event), 16'h0);

    // Make then break of W
    ev_cnt = 0;
    send(8'h1D);
    check("w_make", 16'(p1keys), 16'h01);
    check("w_make_ev", 16'(key_event), 16'h1);
    send(8'hF0);
    check("f0_led", 16'(debugLEDs), 16'hF0);
    check("f0_hold", 16'(p1keys), 16'h01);
    check("f0_noev", 16'(key_event), 16'h0);
    send(8'h1D);
    check("w_break", 16'(p1keys), 16'h00);
    check("w_led", 16'(debugLEDs), 16'h1D);
    idle(2);
    check("w_ev_cnt", 16'(ev_cnt), 16'd2);

    // Extended up arrow
    send(8'hE0); send(8'h75);
    check("up_make", 16'(p2keys), 16'h01);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("up_break", 16'(p2keys), 16'h00);
    send(8'h75);
    check("bare75_p2", 16'(p2keys), 16'h00);
    check("bare75_p1", 16'(p1keys), 16'h00);

    // Typematic repeat
    idle(1);
    ev_cnt = 0;
    send(8'h1D); send(8'h1D); send(8'h1D);
    check("typematic", 16'(p1keys), 16'h01);
    idle(2);
    check("typematic_ev", 16'(ev_cnt), 16'd1);
    send(8'hF0); send(8'h1D);
    check("typ_release", 16'(p1keys), 16'h00);

    // Remaining map entries and simultaneous holds
    send(8'h1B); send(8'h23); send(8'h29);
    check("p1_multi", 16'(p1keys), 16'h1A);
    send(8'hE0); send(8'h72); send(8'hE0); send(8'h6B);
    send(8'hE0); send(8'h74); send(8'h5A);
    check("p2_multi", 16'(p2keys), 16'h1E);
    send(8'hF0); send(8'h1B); send(8'hF0); send(8'h23); send(8'hF0); send(8'h29);
    send(8'hE0); send(8'hF0); send(8'h72); send(8'hE0); send(8'hF0); send(8'h6B);
    send(8'hE0); send(8'hF0); send(8'h74); send(8'hF0); send(8'h5A);
    check("multi_clr_p1", 16'(p1keys), 16'h00);
    check("multi_clr_p2", 16'(p2keys), 16'h00);

    // Break of a key not held
    idle(1);
    send(8'hF0); send(8'h29);
    check("nohold_brk", 16'(p1keys), 16'h00);
    check("nohold_ev", 16'(key_event), 16'h0);

    // frame_err with a simultaneous code_valid
    send(8'h1C); send(8'h5A);
    check("hold_p1", 16'(p1keys), 16'h04);
    check("hold_p2", 16'(p2keys), 16'h10);
    code = 8'h1D; code_valid = 1'b1; frame_err = 1'b1;
    @(negedge clk);
    code_valid = 1'b0; frame_err = 1'b0;
    $display("frame_err -> p1=%05b p2=%05b led=%02h", p1keys, p2keys, debugLEDs);
    check("ferr_p1", 16'(p1keys), 16'h00);
    check("ferr_p2", 16'(p2keys), 16'h00);
    check("ferr_led", 16'(debugLEDs), 16'h5A);
    check("ferr_ev", 16'(key_event), 16'h1);
    send(8'h23);
    check("ferr_then_d", 16'(p1keys), 16'h08);
    // frame_err mid-prefix drops E0
    send(8'hE0);
    frame_err = 1'b1;
    @(negedge clk);
    frame_err = 1'b0;
    send(8'h75);
    check("ferr_ext_drop", 16'(p2keys), 16'h00);

    // Overrun code mid-prefix
    send(8'h23);
    send(8'hE0); send(8'hFF);
    check("ovr_p1", 16'(p1keys), 16'h00);
    check("ovr_ev", 16'(key_event), 16'h1);
    send(8'h75);
    check("ovr_idle", 16'(p2keys), 16'h00);

    // Prefix aborts and repeated E0
    send(8'hF0); send(8'hE0); send(8'h75);
    check("brk_e0_abort", 16'(p2keys), 16'h00);
    send(8'hE0); send(8'hE0); send(8'h75);
    check("ext_e0_e0", 16'(p2keys), 16'h01);
    send(8'hE0); send(8'hF0); send(8'hE0); send(8'h75);
    check("extbrk_abort", 16'(p2keys), 16'h01);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("up_clr2", 16'(p2keys), 16'h00);

    // Timeout: TO idle cycles abandon F0
    send(8'hF0);
    idle(TO);
    send(8'h29);
    check("timeout_make", 16'(p1keys), 16'h10);
    // One cycle short of timeout: still a break
    send(8'hF0);
    idle(TO - 1);
    send(8'h29);
    check("timeout_edge", 16'(p1keys), 16'h00);

    // Reset mid-sequence after E0 F0
    send(8'h1D);
    send(8'hE0); send(8'hF0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_p1", 16'(p1keys), 16'h00);
    check("mrst_p2", 16'(p2keys), 16'h00);
    check("mrst_led", 16'(debugLEDs), 16'h00);
    check("mrst_ev", 16'(key_event), 16'h0);
    send(8'h75);
    check("mrst_75_p2", 16'(p2keys), 16'h00);
    check("mrst_75_led", 16'(debugLEDs), 16'h75);

    // Reset wins over a simultaneous byte
    code = 8'h1D; code_valid = 1'b1; rst = 1'b1;
    @(negedge clk);
    code_valid = 1'b0; rst = 1'b0;
    check("rst_prio_p1", 16'(p1keys), 16'h00);
    check("rst_prio_led", 16'(debugLEDs), 16'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_key_ctrl.md
PS2_KEY_CTRL -- requirements
Module: ps2_key_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 100000, cycles without a byte before a pending prefix is abandoned.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 code  input  8  scancode byte from the PS/2 receiver; valid only when code_valid=1.
REQ-005 code_valid  input  1  single-cycle strobe, one per received byte.
REQ-006 frame_err  input  1  single-cycle strobe: the receiver saw a parity, start or stop error.
REQ-007 p1keys  output  5  player-1 held keys; bit 0 up, 1 down, 2 left, 3 right, 4 fire.
REQ-008 p2keys  output  5  player-2 held keys; same bit order.
REQ-009 debugLEDs  output  8  last accepted code byte.
REQ-010 key_event  output  1  one-cycle pulse when any p1keys/p2keys bit changes.

Function
REQ-011 The key map SHALL be:
- p1, non-extended: W 0x1D up, S 0x1B down, A 0x1C left, D 0x23 right, Space 0x29 fire.
- p2, extended (E0-prefixed): 0x75 up, 0x72 down, 0x6B left, 0x74 right.
- p2 fire: non-extended Enter 0x5A.
- All other codes are unmapped.
REQ-012 The FSM SHALL have four states: IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 F0 seen).
REQ-013 IDLE transitions on code_valid:
- 0xE0 -> EXT.
- 0xF0 -> BRK.
- Any other code -> non-extended make: set the mapped bit, stay in IDLE.
REQ-014 EXT transitions on code_valid:
- 0xF0 -> EXT_BRK.
- 0xE0 -> stay in EXT.
- Any other code -> extended make: set the mapped bit, go to IDLE.
REQ-015 BRK on code_valid: a non-prefix code clears its non-extended mapped bit; the FSM goes to IDLE.
REQ-016 EXT_BRK on code_valid: a non-prefix code clears its extended mapped bit; the FSM goes to IDLE.
REQ-017 In BRK or EXT_BRK, receipt of 0xE0 or 0xF0 SHALL return the FSM to IDLE with no key change.
REQ-018 Unmapped codes SHALL change no key bit but SHALL still follow the state transitions.
REQ-019 Latency: key bits, debugLEDs and key_event SHALL update on the first rising edge after the code_valid cycle.
REQ-020 A repeated make of a held key (typematic) SHALL leave the bit at 1 and SHALL NOT pulse key_event.
REQ-021 A break of a key that is not held SHALL be a no-op.
REQ-022 Both players' bits SHALL be independent; simultaneous holds are allowed.
REQ-023 Codes 0x00 and 0xFF (keyboard overrun/error):
- Clear all key bits.
- Return the FSM to IDLE.
- Pulse key_event if any bit was set.
REQ-024 frame_err=1 SHALL take priority over code_valid in the same cycle:
- The code is ignored.
- All key bits are cleared.
- The FSM returns to IDLE.
- debugLEDs is unchanged.
REQ-025 Idle counter:
- Reset to 0 on every code_valid.
- Counts only while the FSM is not in IDLE.
- On reaching TIMEOUT_CYCLES-1 the FSM returns to IDLE with no key change.
- The counter saturates and never wraps.
REQ-026 debugLEDs SHALL load code on every code_valid without frame_err, prefixes included.

Reset
REQ-027 When rst=1 at a clock edge, every output SHALL read 0 after that edge; all in-progress prefix sequences are discarded:
- FSM = IDLE, counter = 0.
- p1keys = 0, p2keys = 0.
- debugLEDs = 0x00, key_event = 0.
REQ-028 rst SHALL take priority over code_valid and frame_err.

Structure
REQ-029 The shared package ps2_pkg SHALL hold:
- Scancode constants: E0, F0, 00, FF and the mapped keys.
- The FSM state enumeration.
- The key bit indices UP/DOWN/LEFT/RIGHT/FIRE.
REQ-030 A combinational sub-module ps2_keymap SHALL map (code, ext) to (hit, player, bit index); the FSM and registers stay in ps2_key_ctrl.

Verification
REQ-031 Bytes 1D, then F0 1D -> p1keys 00001 then 00000; key_event pulses twice; debugLEDs ends at 0x1D.
REQ-032 Bytes E0 75, then E0 F0 75 -> p2keys 00001 then 00000; a bare 75 (no E0) leaves p2keys = 0.
REQ-033 Bytes 1D 1D 1D -> p1keys 00001; key_event pulses once only.
REQ-034 Bytes 1C and 5A held, then a frame_err strobe -> p1keys and p2keys = 0, FSM = IDLE; a following 23 sets p1keys = 01000.
REQ-035 Byte F0, then TIMEOUT_CYCLES idle cycles, then 29 -> p1keys = 10000 (make, not break).
REQ-036 rst asserted mid-sequence after E0 F0, then 75 -> all outputs 0 after reset; the 75 is treated as non-extended (unmapped); p2keys stays 0.
